// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, constants and BCD helper for the stopwatch
package stopwatch_pkg;

   typedef enum logic {STOP = 1'b0, RUN = 1'b1} sw_state_e;
   typedef logic [3:0]  bcd_t;
   typedef logic [15:0] digit_vec_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // Returns {carry_out, incremented digits}; carry_out marks the 9999 -> 0000 wrap.
   function automatic logic [16:0] bcd_inc(input digit_vec_t d);
      logic [16:0] r;
      logic        carry;
      r     = '0;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry && (d[i*4 +: 4] == BCD_MAX)) begin
            r[i*4 +: 4] = 4'd0;
         end else if (carry) begin
            r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
         end else begin
            r[i*4 +: 4] = d[i*4 +: 4];
         end
      end
      r[16] = carry;
      return r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchronizer and counter debounce for an active-low key
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level,
   output logic press_evt,
   output logic release_evt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d   = key_raw;
      sync2_d   = sync1_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      cnt_d     = '0;
      // Any cycle of agreement restarts the stability count.
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d   = sync2_q;
            press_d   = ~sync2_q;
            release_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         level_q   <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         cnt_q     <= cnt_d;
      end
   end

   assign level       = level_q;
   assign press_evt   = press_q;
   assign release_evt = release_q;

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - key-controlled prescaled 4-digit BCD stopwatch
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV         = 500000,
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter int LONG_PRESS_TICKS = 200
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        key,
   output logic [15:0] digits,
   output logic        running,
   output logic        tick,
   output logic        overflow
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = $clog2(LONG_PRESS_TICKS + 1);

   logic          key_level, press_evt, release_evt;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;
   logic          clear_evt;
   sw_state_e     state_q, state_d;
   logic          running_q, running_d;
   digit_vec_t    digits_q, digits_d;
   logic          ovf_q, ovf_d;
   logic [16:0]   inc;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk        (sys_clk),
      .rst_n      (rst_n),
      .key_raw    (key),
      .level      (key_level),
      .press_evt  (press_evt),
      .release_evt(release_evt)
   );

   always_comb begin
      if (pre_q == PW'(TICK_DIV - 1)) begin
         pre_d  = '0;
         tick_d = 1'b1;
      end else begin
         pre_d  = pre_q + PW'(1);
         tick_d = 1'b0;
      end
   end

   // long_q remembers that this press already cleared, so its release does not toggle.
   always_comb begin
      hold_d    = hold_q;
      long_d    = long_q;
      clear_evt = 1'b0;
      if (press_evt) begin
         hold_d = '0;
         long_d = 1'b0;
      end else if (tick_q && !key_level && (hold_q != HW'(LONG_PRESS_TICKS))) begin
         hold_d = hold_q + HW'(1);
         if (hold_q == HW'(LONG_PRESS_TICKS - 1)) begin
            clear_evt = 1'b1;
            long_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STOP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_evt) begin
         state_d = STOP;
      end else if (release_evt && !long_q) begin
         state_d = (state_q == STOP) ? RUN : STOP;
      end
   end

   always_comb begin
      running_d = (state_d == RUN);
   end

   // Counting looks at the pre-transition state; a clear in the same cycle wins.
   always_comb begin
      inc      = bcd_inc(digits_q);
      digits_d = digits_q;
      ovf_d    = ovf_q;
      if (clear_evt) begin
         digits_d = '0;
         ovf_d    = 1'b0;
      end else if (tick_q && (state_q == RUN)) begin
         digits_d = inc[15:0];
         if (inc[16]) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         tick_q    <= 1'b0;
         hold_q    <= '0;
         long_q    <= 1'b0;
         running_q <= 1'b0;
         digits_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         tick_q    <= tick_d;
         hold_q    <= hold_d;
         long_q    <= long_d;
         running_q <= running_d;
         digits_q  <= digits_d;
         ovf_q     <= ovf_d;
      end
   end

   assign digits   = digits_q;
   assign running  = running_q;
   assign tick     = tick_q;
   assign overflow = ovf_q;

endmodule
